// File: rtl/data_sram.sv
// data_sram: single-port data memory with valid/ready request and response
// channels, programmable access latency, byte-lane write strobes and
// out-of-range error reporting. One transaction is in flight at a time.
module data_sram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 32,
  parameter int LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W/8-1:0]   req_sel,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int LANES = DATA_W / 8;
  localparam int B     = $clog2(LANES);
  localparam int IW    = $clog2(DEPTH);

  // Any address bit at or above the top of the word index marks the request
  // as out of range.
  localparam logic [ADDR_W-1:0] HI_MASK = {ADDR_W{1'b1}} << (IW + B);

  // The wait counter is loaded with LAT-1; LAT never exceeds 4.
  localparam logic [1:0] CNT_INIT = 2'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              accept;
  logic              do_access;

  logic              we_q;
  logic [IW-1:0]     idx_q;
  logic [LANES-1:0]  sel_q;
  logic [DATA_W-1:0] wdata_q;
  logic              oor_q;

  logic [DATA_W-1:0] mem [DEPTH];

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter and handshake decode; req_ready depends only on the
  // state and rsp_ready, never on req_valid.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    accept    = 1'b0;
    do_access = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          do_access = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        req_ready = rsp_ready;
        if (rsp_ready) begin
          if (req_valid) begin
            accept  = 1'b1;
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_valid = (state_q == RESP);

  // Capture the request on acceptance so later input changes have no effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      idx_q   <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= req_we;
      idx_q   <= req_addr[IW+B-1:B];
      sel_q   <= req_sel;
      wdata_q <= req_wdata;
      oor_q   <= |(req_addr & HI_MASK);
    end
  end

  // Storage array; only in-range writes commit, lane by lane, at the access edge.
  always_ff @(posedge clk) begin
    if (do_access && we_q && !oor_q) begin
      for (int i = 0; i < LANES; i++) begin
        if (sel_q[i]) begin
          mem[idx_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
        end
      end
    end
  end

  // Response data and error are registered on the edge that enters RESP and
  // then held while the consumer back-pressures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (do_access) begin
      rsp_err   <= oor_q;
      rsp_rdata <= (!we_q && !oor_q) ? mem[idx_q] : '0;
    end
  end

endmodule

// File: tb/tb_data_sram.sv
// tb_data_sram: scoreboard bench for data_sram. Two instances (LAT=1 and
// LAT=3) are driven; expectations come from a word-array model of memory.
module tb_data_sram;

  localparam int DEPTH = 4096;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [3:0]  req_sel   [2];
  logic [31:0] req_wdata [2];
  logic        rsp_ready [2];
  wire         req_ready [2];
  wire         rsp_valid [2];
  wire  [31:0] rsp_rdata [2];
  wire         rsp_err   [2];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  exp_t        sb0[$];
  exp_t        sb1[$];
  logic [31:0] model [2][DEPTH];
  bit          bp_rand [2];
  bit          bp_hold [2];

  data_sram #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .LAT(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_sel(req_sel[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  data_sram #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .LAT(3)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_sel(req_sel[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  // Free-running clock and edge counter used for latency measurement.
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Response-side consumer: always ready, held off, or randomly stalling.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      rsp_ready[u] = bp_hold[u] ? 1'b0 : (bp_rand[u] ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  function automatic int sb_size(input int u);
    if (u == 0) return sb0.size();
    return sb1.size();
  endfunction

  function automatic exp_t sb_front(input int u);
    if (u == 0) return sb0[0];
    return sb1[0];
  endfunction

  function automatic void sb_push(input int u, input exp_t e);
    if (u == 0) sb0.push_back(e);
    else sb1.push_back(e);
  endfunction

  function automatic void sb_pop(input int u);
    if (u == 0) void'(sb0.pop_front());
    else void'(sb1.pop_front());
  endfunction

  function automatic void sb_clear(input int u);
    if (u == 0) sb0.delete();
    else sb1.delete();
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one request and hold it until accepted; the expected response is
  // computed from the model and queued at the moment of acceptance.
  task automatic apply_stimulus(input int u, input bit we, input logic [31:0] addr,
                                input logic [3:0] sel, input logic [31:0] wdata,
                                output bit with_rsp);
    exp_t e;
    int   idx;
    bit   inr;
    int   k;
    with_rsp = 1'b0;
    @(negedge clk);
    req_valid[u] = 1'b1;
    req_we[u]    = we;
    req_addr[u]  = addr;
    req_sel[u]   = sel;
    req_wdata[u] = wdata;
    #1;
    k = 0;
    while (!req_ready[u] && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!req_ready[u]) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout u%0d: req_ready stayed %b, expected 1", u, req_ready[u]);
      req_valid[u] = 1'b0;
      return;
    end
    with_rsp = rsp_valid[u] && rsp_ready[u];
    inr   = (addr >> 14) == 0;
    idx   = int'(addr[13:2]);
    e.acc = cyc + 1;
    e.err = !inr;
    e.rdata = (!we && inr) ? model[u][idx] : 32'h0;
    if (we && inr) begin
      for (int i = 0; i < 4; i++) begin
        if (sel[i]) model[u][idx][i*8 +: 8] = wdata[i*8 +: 8];
      end
    end
    sb_push(u, e);
    @(posedge clk);
  endtask

  task automatic idle(input int u);
    @(negedge clk);
    req_valid[u] = 1'b0;
  endtask

  task automatic single(input int u, input bit we, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] wdata);
    bit d;
    apply_stimulus(u, we, addr, sel, wdata, d);
    idle(u);
  endtask

  task automatic drain(input int u);
    int k;
    k = 0;
    while (sb_size(u) != 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (sb_size(u) != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain_timeout u%0d: %0d responses outstanding, expected 0", u, sb_size(u));
      sb_clear(u);
    end
  endtask

  // Monitor: compares every presented response against the queue head,
  // checks latency on the first valid cycle and stability under back-pressure.
  task automatic monitor(input int u);
    bit   in_rsp;
    exp_t e;
    in_rsp = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        sb_clear(u);
        in_rsp = 1'b0;
      end else if (rsp_valid[u]) begin
        if (sb_size(u) == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_rsp u%0d: rsp_valid=1, expected no response", u);
        end else begin
          e = sb_front(u);
          if (!in_rsp) begin
            check_output($sformatf("latency_u%0d", u), 32'(cyc - e.acc), 32'(lat_of(u)));
            in_rsp = 1'b1;
          end
          check_output($sformatf("rdata_u%0d", u), rsp_rdata[u], e.rdata);
          check_output($sformatf("err_u%0d", u), 32'(rsp_err[u]), 32'(e.err));
          if (!rsp_ready[u]) begin
            check_output($sformatf("req_ready_bp_u%0d", u), 32'(req_ready[u]), 32'h0);
          end else begin
            sb_pop(u);
            in_rsp = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic random_phase(input int u);
    bit          d;
    bit          we;
    logic [31:0] addr;
    for (int n = 0; n < 60; n++) begin
      we = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) addr = $urandom | (32'h1 << $urandom_range(14, 31));
      else addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) idle(u);
      apply_stimulus(u, we, addr, 4'($urandom_range(0, 15)), $urandom, d);
    end
    idle(u);
    drain(u);
  endtask

  // Safety net so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized traffic on both instances.
  initial begin
    bit d;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0;
      req_we[u]    = 1'b0;
      req_addr[u]  = 32'h0;
      req_sel[u]   = 4'h0;
      req_wdata[u] = 32'h0;
      bp_rand[u]   = 1'b0;
      bp_hold[u]   = 1'b0;
    end
    fork
      monitor(0);
      monitor(1);
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int u = 0; u < 2; u++) begin
      check_output($sformatf("reset_rsp_valid_u%0d", u), 32'(rsp_valid[u]), 32'h0);
      check_output($sformatf("reset_rdata_u%0d", u), rsp_rdata[u], 32'h0);
      check_output($sformatf("reset_err_u%0d", u), 32'(rsp_err[u]), 32'h0);
      check_output($sformatf("reset_req_ready_u%0d", u), 32'(req_ready[u]), 32'h1);
    end

    single(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    single(0, 1'b0, 32'h10, 4'h0, 32'h0);
    drain(0);

    single(0, 1'b1, 32'h20, 4'hF, 32'hAAAAAAAA);
    single(0, 1'b1, 32'h20, 4'b0101, 32'h11223344);
    single(0, 1'b0, 32'h20, 4'h0, 32'h0);
    single(0, 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF);
    single(0, 1'b0, 32'h22, 4'h0, 32'h0);
    drain(0);

    single(1, 1'b1, 32'h40, 4'hF, 32'h5A5A1234);
    drain(1);
    bp_hold[1] = 1'b1;
    apply_stimulus(1, 1'b0, 32'h40, 4'h0, 32'h0, d);
    idle(1);
    repeat (5) @(negedge clk);
    #1;
    check_output("bp_valid_held", 32'(rsp_valid[1]), 32'h1);
    bp_hold[1] = 1'b0;
    drain(1);

    apply_stimulus(0, 1'b1, 32'h50, 4'hF, 32'hC0FFEE01, d);
    apply_stimulus(0, 1'b0, 32'h50, 4'h0, 32'h0, d);
    check_output("handoff_1", 32'(d), 32'h1);
    apply_stimulus(0, 1'b1, 32'h54, 4'hF, 32'h12345678, d);
    check_output("handoff_2", 32'(d), 32'h1);
    apply_stimulus(0, 1'b0, 32'h54, 4'h0, 32'h0, d);
    check_output("handoff_3", 32'(d), 32'h1);
    idle(0);
    drain(0);

    single(0, 1'b1, 32'h0, 4'hF, 32'h0BADF00D);
    single(0, 1'b0, 32'h4000, 4'h0, 32'h0);
    single(0, 1'b1, 32'h4000, 4'hF, 32'hFFFFFFFF);
    single(0, 1'b0, 32'h0, 4'h0, 32'h0);
    single(0, 1'b0, 32'h4010, 4'h0, 32'h0);
    drain(0);

    single(1, 1'b1, 32'h30, 4'hF, 32'h01234567);
    drain(1);
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b1;
    req_addr[1]  = 32'h30;
    req_sel[1]   = 4'hF;
    req_wdata[1] = 32'hFFFFFFFF;
    #1;
    check_output("abort_accept_ready", 32'(req_ready[1]), 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    rst_n = 1'b0;
    #1;
    check_output("abort_rsp_valid_in_reset", 32'(rsp_valid[1]), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("abort_req_ready", 32'(req_ready[1]), 32'h1);
    check_output("abort_rsp_valid", 32'(rsp_valid[1]), 32'h0);
    single(1, 1'b0, 32'h30, 4'h0, 32'h0);
    drain(1);

    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 16; i++) single(u, 1'b1, 32'(i * 4), 4'hF, $urandom);
      drain(u);
    end
    bp_rand[0] = 1'b1;
    bp_rand[1] = 1'b1;
    fork
      random_phase(0);
      random_phase(1);
    join
    bp_rand[0] = 1'b0;
    bp_rand[1] = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
